// File: rtl/microgame_gfx_pkg.sv
// Shared graphics definitions: blitter FSM states, rect operand field
// positions (shared with the collision detector) and default screen size.
package microgame_gfx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DRAW = 2'd2
   } blit_state_e;

   localparam int RECT_X_MSB = 31;
   localparam int RECT_X_LSB = 24;
   localparam int RECT_Y_MSB = 23;
   localparam int RECT_Y_LSB = 16;
   localparam int RECT_W_MSB = 15;
   localparam int RECT_W_LSB = 8;
   localparam int RECT_H_MSB = 7;
   localparam int RECT_H_LSB = 0;

   localparam int SCREEN_W_DEF = 256;
   localparam int SCREEN_H_DEF = 256;

endpackage

// File: rtl/blit_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata_o while non-empty.
module blit_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;

   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap naturally.
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/rect_blitter.sv
// Rectangle-fill engine: queues draw commands and writes one clipped pixel
// per cycle into the framebuffer, honouring framebuffer back-pressure.
module rect_blitter
   import microgame_gfx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int COLOR_WIDTH = 8,
   parameter int SCREEN_W    = SCREEN_W_DEF,
   parameter int SCREEN_H    = SCREEN_H_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [31:0]            cmd_rect,
   input  logic [COLOR_WIDTH-1:0] cmd_color,
   output logic                   fb_we,
   output logic [15:0]            fb_addr,
   output logic [COLOR_WIDTH-1:0] fb_wdata,
   input  logic                   fb_stall,
   output logic                   busy
);

   localparam int EW = 32 + COLOR_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [8:0]    SW9 = 9'(SCREEN_W);
   localparam logic [8:0]    SH9 = 9'(SCREEN_H);

   logic [EW-1:0]  head;
   logic           full, empty, push, pop;
   logic [CW-1:0]  fifo_cnt;

   blit_state_e            state_q, state_d;
   logic [7:0]             x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
   logic [7:0]             cx_q, cx_d, cy_q, cy_d;
   logic [COLOR_WIDTH-1:0] col_q, col_d;

   logic [8:0] px, py;
   logic       in_screen, advance, more_after_pop;
   logic [7:0] hw, hh;

   assign push      = cmd_valid && !full;
   assign cmd_ready = !full;

   blit_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({cmd_color, cmd_rect}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_cnt)
   );

   // 9-bit sums so that a rectangle running off the right/bottom edge clips
   // instead of wrapping back to column/row 0.
   assign px        = {1'b0, x0_q} + {1'b0, cx_q};
   assign py        = {1'b0, y0_q} + {1'b0, cy_q};
   assign in_screen = (px < SW9) && (py < SH9);

   assign fb_we    = (state_q == ST_DRAW) && in_screen;
   assign fb_addr  = {py[7:0], px[7:0]};
   assign fb_wdata = col_q;
   assign busy     = !empty || (state_q != ST_IDLE);

   // Clipped pixels never wait on the framebuffer.
   assign advance        = (state_q == ST_DRAW) && !(fb_we && fb_stall);
   assign more_after_pop = !empty && (fifo_cnt != CNT_ONE);
   assign hw             = head[RECT_W_MSB:RECT_W_LSB];
   assign hh             = head[RECT_H_MSB:RECT_H_LSB];

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pop   = 1'b1;
            x0_d  = head[RECT_X_MSB:RECT_X_LSB];
            y0_d  = head[RECT_Y_MSB:RECT_Y_LSB];
            w_d   = hw;
            h_d   = hh;
            col_d = head[EW-1:32];
            cx_d  = '0;
            cy_d  = '0;
            if (hw == '0 || hh == '0)
               state_d = more_after_pop ? ST_LOAD : ST_IDLE;
            else
               state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (advance) begin
               if (cx_q == w_q - 8'd1) begin
                  cx_d = '0;
                  cy_d = cy_q + 8'd1;
                  if (cy_q == h_q - 8'd1)
                     state_d = empty ? ST_IDLE : ST_LOAD;
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

endmodule

// File: tb/tb_rect_blitter.sv
// Directed bench for rect_blitter: latency, clipping, empty rects,
// back-pressure, mid-row stall and reset mid-draw.
module tb_rect_blitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_rect;
   logic [7:0]  cmd_color;
   logic        fb_we;
   logic [15:0] fb_addr;
   logic [7:0]  fb_wdata;
   logic        fb_stall;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] wlog [$];
   logic [7:0]  dlog [$];
   logic [15:0] exp_b [4] = '{16'h140A, 16'h140B, 16'h150A, 16'h150B};

   rect_blitter #(
      .FIFO_DEPTH  (4),
      .COLOR_WIDTH (8),
      .SCREEN_W    (256),
      .SCREEN_H    (256)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rect  (cmd_rect),
      .cmd_color (cmd_color),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .fb_stall  (fb_stall),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && fb_we && !fb_stall) begin
         wlog.push_back(fb_addr);
         dlog.push_back(fb_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] w, input logic [7:0] h,
                       input logic [7:0] col);
      cmd_valid = 1'b1;
      cmd_rect  = {x, y, w, h};
      cmd_color = col;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   function automatic logic [15:0] wl(input int k);
      return (wlog.size() > k) ? wlog[k] : 16'hDEAD;
   endfunction

   initial begin
      int acc;
      int c;
      logic rdy;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_rect  = '0;
      cmd_color = '0;
      fb_stall  = 1'b0;
      repeat (2) tick();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_we",    fb_we,     0);
      chk("rst_addr",  fb_addr,   0);
      chk("rst_wdata", fb_wdata,  0);
      chk("rst_busy",  busy,      0);
      rst_n = 1'b1;
      tick();

      // basic 2x2: pixels on N+3..N+6, idle on N+7
      send(8'd10, 8'd20, 8'd2, 8'd2, 8'h5A);
      chk("b_busy_n1", busy, 1);
      chk("b_we_n1",   fb_we, 0);
      tick();
      chk("b_we_n2",   fb_we, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("b_we",   fb_we,    1);
         chk("b_addr", fb_addr,  exp_b[k]);
         chk("b_data", fb_wdata, 8'h5A);
      end
      tick();
      chk("b_busy_end", busy, 0);
      chk("b_nwr", wlog.size(), 4);

      // right-edge clipping, no wrap to x=0
      wlog.delete(); dlog.delete();
      send(8'd254, 8'd3, 8'd4, 8'd1, 8'h33);
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("c_we", fb_we, (k < 2) ? 1 : 0);
      end
      tick();
      chk("c_busy_end", busy, 0);
      chk("c_nwr", wlog.size(), 2);
      chk("c_a0", wl(0), 16'h03FE);
      chk("c_a1", wl(1), 16'h03FF);

      // zero-width rectangle
      wlog.delete(); dlog.delete();
      send(8'd5, 8'd5, 8'd0, 8'd5, 8'h01);
      chk("e_busy1", busy, 1);
      tick();
      chk("e_busy2", busy, 1);
      chk("e_we",    fb_we, 0);
      tick();
      chk("e_busy3", busy, 0);
      chk("e_nwr", wlog.size(), 0);

      // back-pressure: stall on first pixel while five 1x1 commands are offered
      wlog.delete(); dlog.delete();
      fb_stall = 1'b1;
      send(8'd1, 8'd1, 8'd3, 8'd1, 8'h11);
      tick();
      tick();
      chk("bp_addr0", fb_addr, 16'h0101);
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         cmd_valid = 1'b1;
         cmd_rect  = {8'h20 + acc[7:0], 8'h40, 8'd1, 8'd1};
         cmd_color = 8'h20 + acc[7:0];
         rdy = cmd_ready;
         tick();
         if (rdy) acc++;
      end
      chk("bp_acc4",  acc, 4);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_hold",  fb_addr, 16'h0101);
      chk("bp_nwr0",  wlog.size(), 0);
      fb_stall = 1'b0;
      c = 0;
      while (acc < 5 && c < 50) begin
         cmd_valid = 1'b1;
         cmd_rect  = {8'h20 + acc[7:0], 8'h40, 8'd1, 8'd1};
         cmd_color = 8'h20 + acc[7:0];
         rdy = cmd_ready;
         tick();
         if (rdy) acc++;
         c++;
      end
      cmd_valid = 1'b0;
      chk("bp_acc5", acc, 5);
      wait_idle(100);
      chk("bp_nwr", wlog.size(), 8);
      for (int k = 0; k < 8; k++)
         chk("bp_addr", wl(k), (k < 3) ? 16'h0101 + 16'(k) : {8'h40, 8'h20 + 8'(k - 3)});

      // mid-row stall on cx=2
      wlog.delete(); dlog.delete();
      send(8'h30, 8'h50, 8'd4, 8'd1, 8'h44);
      repeat (4) tick();
      chk("m_addr_cx2", fb_addr, 16'h5032);
      fb_stall = 1'b1;
      tick();
      chk("m_hold", fb_addr, 16'h5032);
      chk("m_we",   fb_we, 1);
      fb_stall = 1'b0;
      wait_idle(20);
      chk("m_nwr", wlog.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("m_addr", wl(k), 16'h5030 + 16'(k));

      // reset during a 16x16 draw with a second command queued
      wlog.delete(); dlog.delete();
      send(8'd0, 8'd0, 8'd16, 8'd16, 8'h07);
      send(8'd100, 8'd100, 8'd2, 8'd2, 8'h08);
      tick();
      repeat (37) tick();
      chk("r_addr37", fb_addr, 16'h0205);
      rst_n = 1'b0;
      #1;
      chk("r_we",    fb_we, 0);
      chk("r_busy",  busy, 0);
      chk("r_ready", cmd_ready, 1);
      chk("r_nwr_before", wlog.size(), 37);
      wlog.delete(); dlog.delete();
      tick();
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("r_nwr_after", wlog.size(), 0);
      chk("r_busy_after", busy, 0);
      send(8'd7, 8'd8, 8'd1, 8'd1, 8'h99);
      wait_idle(20);
      chk("r_new_nwr",  wlog.size(), 1);
      chk("r_new_addr", wl(0), 16'h0807);
      chk("r_new_data", (dlog.size() > 0) ? dlog[0] : 8'h00, 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
